// File: rtl/mirfak_pkg.sv
// Shared constants for the mirfak register-file write path.
package mirfak_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

endpackage

// File: rtl/mirfak_rr_arbiter.sv
// N-way request arbiter producing a one-hot (or zero) grant.
// Build option MIRFAK_WB_RR_EN: round-robin with a rotating pointer;
// otherwise fixed priority where the lowest index wins.
module mirfak_rr_arbiter
  import mirfak_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

`ifdef MIRFAK_WB_RR_EN
  localparam int unsigned PW = $clog2(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic          found;

  // Two passes: indices at/after the pointer first, then the wrapped ones.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= 32'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i] && (i < 32'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // Pointer moves to the slot after the granted source.
  always_comb begin
    ptr_nxt = ptr;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) begin
        ptr_nxt = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  // Pointer register; any grant is a transfer since grant implies a valid request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt;
    end
  end
`else
  logic unused_ports;
  assign unused_ports = clk ^ rst_n;

  // Fixed priority: isolate the lowest set request bit.
  always_comb begin
    grant = req & ~(req - N'(1));
  end
`endif

endmodule

// File: rtl/mirfak_wb_arbiter.sv
// Writeback arbiter: shares the register-file write port among N_REQ
// sources and tracks pending writes in a 32-entry scoreboard.
// Build option MIRFAK_WB_RR_EN selects round-robin arbitration.
module mirfak_wb_arbiter
  import mirfak_pkg::*;
#(
  parameter int unsigned N_REQ = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [REG_ADDR_W*N_REQ-1:0] req_addr_i,
  input  logic [XLEN*N_REQ-1:0]       req_data_i,
  output logic [N_REQ-1:0]            req_ready_o,
  output logic [REG_ADDR_W-1:0]       waddr_o,
  output logic [XLEN-1:0]             wdata_o,
  output logic                        wen_o,
  input  logic                        alloc_i,
  input  logic [REG_ADDR_W-1:0]       alloc_addr_i,
  input  logic [REG_ADDR_W-1:0]       raddr_a_i,
  input  logic [REG_ADDR_W-1:0]       raddr_b_i,
  output logic                        hazard_a_o,
  output logic                        hazard_b_o,
  output logic [NUM_REGS-1:0]         busy_o
);

  logic [N_REQ-1:0]      grant;
  logic                  xfer;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [XLEN-1:0]       sel_data;
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_nxt;

  mirfak_rr_arbiter #(.N(N_REQ)) u_arb (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .req   (req_valid_i),
    .grant (grant)
  );

  // Grants are suppressed while reset is held so no handshake can complete.
  assign req_ready_o = grant & {N_REQ{rst_ni}};
  assign xfer        = |req_ready_o;

  // Select the granted source's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_ready_o[i]) begin
        sel_addr = req_addr_i[REG_ADDR_W*i +: REG_ADDR_W];
        sel_data = req_data_i[XLEN*i +: XLEN];
      end
    end
  end

  // Registered write port; x0 writes complete the handshake but never enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wen_o   <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
    end else if (xfer) begin
      wen_o   <= (sel_addr != '0);
      waddr_o <= sel_addr;
      wdata_o <= sel_data;
    end else begin
      wen_o   <= 1'b0;
    end
  end

  // Scoreboard update: clear on commit, then set on alloc so set wins on collision.
  always_comb begin
    busy_nxt = busy;
    if (wen_o) begin
      busy_nxt[waddr_o] = 1'b0;
    end
    if (alloc_i && (alloc_addr_i != '0)) begin
      busy_nxt[alloc_addr_i] = 1'b1;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign busy_o     = busy;
  assign hazard_a_o = (raddr_a_i != '0) && busy[raddr_a_i];
  assign hazard_b_o = (raddr_b_i != '0) && busy[raddr_b_i];

endmodule

// File: doc/mirfak_wb_arbiter.md
Name: mirfak_wb_arbiter

Overview:
Shares the register file's single write port between N_REQ writeback sources (e.g. ALU, load unit, CSR/mul-div) using valid/ready handshakes.
Drives the register file write port (waddr/wdata/wen) from a registered output stage.
Also keeps a 32-entry pending-write scoreboard so decode can detect RAW hazards on the two read addresses.

Parameters:
N_REQ, 3, number of writeback requesters; legal range 2..4; index 0 is the lowest index.

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  N_REQ  per-source write request valid
req_addr_i  in  5*N_REQ  per-source destination register; source i occupies bits [5i+4:5i]
req_data_i  in  32*N_REQ  per-source write data; source i occupies bits [32i+31:32i]
req_ready_o  out  N_REQ  per-source grant; one-hot or zero
waddr_o  out  5  register file write address
wdata_o  out  32  register file write data
wen_o  out  1  register file write enable
alloc_i  in  1  decode issues an instruction with a destination register
alloc_addr_i  in  5  destination register of the issued instruction
raddr_a_i  in  5  decode read address A
raddr_b_i  in  5  decode read address B
hazard_a_o  out  1  busy[raddr_a_i]; 0 when raddr_a_i==0
hazard_b_o  out  1  busy[raddr_b_i]; 0 when raddr_b_i==0
busy_o  out  32  scoreboard bitmap; bit 0 is always 0

Behaviour:
- Reset (async, rst_ni=0): wen_o=0, waddr_o=0, wdata_o=0, busy=0, priority pointer=0, req_ready_o=0.
- Arbitration is combinational within the cycle:
  - Exactly one valid source receives req_ready_o=1; none when no request is valid.
  - A transfer occurs when valid&ready.
  - req_ready_o may depend on req_valid_i. Sources must not depend on ready to raise valid.
- Output stage:
  - On a transfer, the next edge registers waddr_o=addr, wdata_o=data, and wen_o=(addr!=0).
  - With no transfer, wen_o=0 at the next edge; waddr_o and wdata_o hold.
  - Latency is 1 cycle and throughput is 1 write/cycle. The output stage never stalls.
- A write to x0 completes its handshake but never asserts wen_o.
- Held request: a source with valid=1 and ready=0 keeps its addr and data stable until granted. The arbiter does not check this.
- Scoreboard:
  - Set: alloc_i=1 and alloc_addr_i!=0 set busy[alloc_addr_i] at the edge.
  - Clear: while wen_o=1, busy[waddr_o] clears at the next edge.
  - Same address set and cleared in the same cycle: set wins (the newer producer is pending).
  - Different addresses: both updates apply.
  - alloc of an already-busy register: stays busy. No counting; a single outstanding writer per register is a pipeline invariant.
- Hazard outputs are combinational from the busy register. They are not bypassed by the write committing in the same cycle.
- Reset mid-operation: any pending grant or registered write is dropped (wen_o=0 immediately, asynchronously) and busy is cleared.

Optional Feature:
MIRFAK_WB_RR_EN
- Defined: round-robin arbitration.
  - Search starts at the pointer; the first valid source at or after it (mod N_REQ) wins.
  - After a transfer to source i, the pointer becomes (i+1) mod N_REQ. The pointer holds when there is no transfer.
- Undefined: fixed priority; the lowest index wins. There is no pointer register; the pointer logic is removed.

Decomposition:
- Shared package mirfak_pkg holds the constants XLEN=32, REG_ADDR_W=5 and NUM_REGS=32.
- Sub-module mirfak_rr_arbiter:
  - Takes N_REQ request bits in and produces a one-hot grant.
  - Contains the pointer register under MIRFAK_WB_RR_EN and the fixed-priority logic otherwise.
  - Reused for the future memory-port arbiter.

Test Plan:
- Single source: src1 valid, addr=5, data=0xDEADBEEF → ready[1]=1 the same cycle. Next cycle: wen_o=1, waddr_o=5, wdata_o=0xDEADBEEF. The cycle after: wen_o=0.
- All 3 sources valid for 3 cycles (addr 1/2/3):
  - RR_EN: grants 0,1,2, giving waddr_o sequence 1,2,3.
  - Without RR_EN: source 0 is granted 3 times.
- x0 write: src0 addr=0, data=0x1234 → ready[0]=1, but wen_o stays 0 the next cycle.
- Scoreboard: alloc addr=7 → busy_o[7]=1 and hazard_a_o=1 with raddr_a_i=7. After the src2 write to 7 commits, busy_o[7]=0 one edge after wen_o.
- Set/clear collision: wen_o=1 with waddr_o=9 while alloc_i=1, alloc_addr_i=9 → busy_o[9]=1 after the edge. alloc addr=0 → busy_o[0]=0 always.
- Reset mid-op: assert rst_ni=0 while wen_o=1 and busy=0x0000_0F00 → wen_o=0 and busy_o=0 immediately, without waiting for a clock edge. The pointer returns to 0, so source 0 wins the first post-reset contention.
